lvt_multiport_ram: RTL and testbench
====================================

# lvt_multiport_ram

Inferable multi-write, multi-read RAM with asynchronous (combinational) reads. It is built from one single-write bank per write port plus a live value table (LVT) that records which bank holds the newest value of each address. A reset-triggered sequencer sweeps the memory to zero, because FPGA RAM cannot be cleared in one cycle. It is the general-purpose register-file/scoreboard storage for FPGA builds that need more than one write port.

## Interface
- ADDR_WIDTH, 10, address width of every port
- DATA_DEPTH, 1024, number of entries; must satisfy DATA_DEPTH <= 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width
- NUM_WR, 2, write ports (>= 1)
- NUM_RD, 3, read ports (>= 1)
- WR_BYPASS, 0, 1 = reads see same-cycle writes combinationally
- Clk_CI  in  1  single clock
- Rst_RI  in  1  reset, synchronous, active-high
- Ready_SO  out  1  high when init sweep done and RAM accepts writes
- WrEn_SI  in  NUM_WR  per-port write enable
- WrAddr_DI  in  NUM_WR x ADDR_WIDTH  write addresses
- WrData_DI  in  NUM_WR x DATA_WIDTH  write data
- RdAddr_DI  in  NUM_RD x ADDR_WIDTH  read addresses
- RdData_DO  out  NUM_RD x DATA_WIDTH  read data, combinational from RdAddr_DI
- WrCollision_SO  out  1  registered one-cycle pulse: two or more enabled write ports hit the same address in the previous cycle

## Operation
- Storage: NUM_WR banks of DATA_DEPTH x DATA_WIDTH. Bank w is written only by port w.
- LVT: DATA_DEPTH entries of LVT_W = max(1, $clog2(NUM_WR)) bits. A write by port w stores w into the LVT entry for its address.
- Read port r returns bank[LVT[RdAddr_DI[r]]][RdAddr_DI[r]].
- State machine, states INIT and READY:
  - Rst_RI=1 forces INIT with InitCnt=0, from any state. This also applies during a sweep; the sweep restarts.
  - In INIT, each cycle writes 0 to bank 0 at InitCnt and writes 0 to LVT[InitCnt], then increments InitCnt.
  - INIT moves to READY after the cycle that writes InitCnt = DATA_DEPTH-1.
  - READY holds until reset.
- During INIT:
  - WrEn_SI is ignored.
  - RdData_DO is forced to 0.
  - Ready_SO = 0.
- Write collision: the lowest-index port wins, and only the winner's bank and LVT entry are updated. WrCollision_SO pulses in the next cycle.
- Out-of-range address (>= DATA_DEPTH):
  - Write is dropped; no bank or LVT update and no collision.
  - Read returns 0.
- WR_BYPASS=1: if any enabled in-range write in the current cycle matches RdAddr_DI[r], RdData_DO[r] returns the winning port's WrData_DI combinationally.
- Reset values:
  - Ready_SO = 0, WrCollision_SO = 0, RdData_DO = 0.
  - Memory contents are all zero once Ready_SO rises.

## Timing
- Read latency is 0 cycles, combinational from address.
- A write at edge k is visible on reads after edge k. With WR_BYPASS=1 it is also visible in the cycle before edge k.
- Init duration: if Rst_RI is sampled high at edge 0 and low from edge 1 onward, Ready_SO rises after edge DATA_DEPTH and first write is accepted at edge DATA_DEPTH+1.
- WrCollision_SO is high for exactly one cycle per colliding cycle. Back-to-back collisions hold it high.
- Simultaneous reset and write: reset wins and the write is dropped.

## Structure
- Package lvt_ram_pkg holds:
  - state enum (INIT, READY);
  - function lvt_width(num_wr) returning max(1, $clog2(num_wr));
  - function for the lowest-index-wins collision resolution.
- Sub-module lvt_ram_bank: 1 write port, NUM_RD async read ports, no reset. Instantiate NUM_WR times.
- The LVT is a further instance of lvt_ram_bank with DATA_WIDTH = LVT_W and NUM_RD read ports.
- Top level holds the FSM, init counter, write-port arbitration, bypass mux and the collision register.
- Simulation-only assertions:
  - DATA_DEPTH <= 2**ADDR_WIDTH;
  - NUM_WR >= 1 and NUM_RD >= 1.

## Test plan
- Reset sweep: DATA_DEPTH=16, pulse Rst_RI for 1 cycle -> Ready_SO=0 for 16 cycles, then 1. All 16 addresses read 0 on every read port.
- Per-port writes: port0 writes 0xA5A5_0001 to addr 3, then port1 writes 0x5A5A_0002 to addr 3 a cycle later -> all read ports return 0xA5A5_0001, then 0x5A5A_0002. Addr 4 stays 0.
- Collision: ports 0 and 1 both write addr 7 in one cycle (0x11 vs 0x22) -> addr 7 reads 0x11. WrCollision_SO is high exactly the next cycle.
- Bypass: WR_BYPASS=1, port1 writes 0xDEAD to addr 9 while RdAddr_DI[2]=9 -> RdData_DO[2]=0xDEAD in the same cycle. With WR_BYPASS=0, the old value shows that cycle and 0xDEAD the next.
- Reset mid-sweep and mid-operation: assert Rst_RI at InitCnt=5 -> the sweep restarts and takes the full DATA_DEPTH cycles. Reset after writes -> all data returns to 0.
- Out of range: DATA_DEPTH=12, ADDR_WIDTH=4, write 0xFF to addr 13 -> no collision and no effect. Reading addr 13 returns 0; addresses 0-11 are unchanged.

Source files
------------

// File: rtl/lvt_ram_pkg.sv
// Shared types and helpers for the live-value-table multi-port RAM.
package lvt_ram_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int MAX_WR = 32;

    function automatic int lvt_width(input int num_wr);
        int w;
        w = $clog2(num_wr);
        return (w < 1) ? 1 : w;
    endfunction

    // Lowest-index-wins resolution: index of the lowest set request bit.
    function automatic int lowest_set(input logic [MAX_WR-1:0] req);
        int idx;
        idx = 0;
        for (int i = MAX_WR - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lvt_ram_bank.sv
// Unreset storage bank with NUM_WP write ports and NUM_RD asynchronous read ports.
module lvt_ram_bank #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 3,
    parameter int NUM_WP     = 1
) (
    input  logic                                   clk,
    input  logic [NUM_WP-1:0]                      wr_en,
    input  logic [NUM_WP-1:0][ADDR_WIDTH-1:0]      wr_addr,
    input  logic [NUM_WP-1:0][DATA_WIDTH-1:0]      wr_data,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]      rd_addr,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]      rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    // Write ports; callers guarantee distinct addresses among enabled ports.
    always_ff @(posedge clk) begin
        for (int p = NUM_WP - 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                mem_q[wr_addr[p]] <= wr_data[p];
            end
        end
    end

    // Asynchronous reads.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data[r] = mem_q[rd_addr[r]];
        end
    end

endmodule

// File: rtl/lvt_ram_checker.sv
// Elaboration-constant sanity properties for the LVT RAM parameters.
module lvt_ram_checker #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DEPTH = 1024,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 3
) (
    input logic clk
);

    a_depth_fits: assert property (@(posedge clk) 64'(DATA_DEPTH) <= (64'd1 << ADDR_WIDTH));
    a_port_counts: assert property (@(posedge clk) (NUM_WR >= 1) && (NUM_RD >= 1));

endmodule

// File: rtl/lvt_multiport_ram.sv
// Multi-write, multi-read RAM: one bank per write port, a live value table
// selecting the newest bank per address, and a reset-driven zeroing sweep.
module lvt_multiport_ram
    import lvt_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 3,
    parameter int WR_BYPASS  = 0
) (
    input  logic                              Clk_CI,
    input  logic                              Rst_RI,
    output logic                              Ready_SO,
    input  logic [NUM_WR-1:0]                 WrEn_SI,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] WrAddr_DI,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] WrData_DI,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] RdAddr_DI,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0] RdData_DO,
    output logic                              WrCollision_SO
);

    localparam int                    LVT_W    = lvt_width(NUM_WR);
    localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DATA_DEPTH - 1);

    state_e                                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]                       init_cnt_q, init_cnt_d;
    logic                                        coll_q, coll_d;
    logic                                        ready_s, sweep_s;
    logic [NUM_WR-1:0]                           wr_valid_s, wr_win_s;
    logic [NUM_WR-1:0]                           port_en_s;
    logic [NUM_WR-1:0][ADDR_WIDTH-1:0]           port_addr_s;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0]           port_data_s;
    logic [NUM_WR-1:0][LVT_W-1:0]                lvt_data_s;
    logic [NUM_RD-1:0][LVT_W-1:0]                lvt_rdata_s;
    logic [NUM_WR-1:0][NUM_RD-1:0][DATA_WIDTH-1:0] bank_rdata_s;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]           rd_data_s;

    assign ready_s = (state_q == READY);
    assign sweep_s = (state_q == INIT) && !Rst_RI;

    // Sweep sequencer next state: count through every entry, then hold READY.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                if (init_cnt_q == LAST_IDX) begin
                    state_d    = READY;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_WIDTH'(1'b1);
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // State, sweep counter and collision flag registers.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            coll_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            coll_q     <= coll_d;
        end
    end

    // Qualify user writes and keep only the lowest-index port per address.
    always_comb begin
        logic [MAX_WR-1:0] same_v;
        same_v     = '0;
        wr_valid_s = '0;
        wr_win_s   = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_valid_s[w] = WrEn_SI[w] && ready_s && !Rst_RI
                            && ({1'b0, WrAddr_DI[w]} < DEPTH_X);
        end
        for (int w = 0; w < NUM_WR; w++) begin
            same_v = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                same_v[j] = wr_valid_s[j] && (WrAddr_DI[j] == WrAddr_DI[w]);
            end
            wr_win_s[w] = wr_valid_s[w] && (lowest_set(same_v) == w);
        end
        coll_d = |(wr_valid_s & ~wr_win_s);
    end

    // Bank/LVT write ports; port 0 is borrowed by the sweep during INIT.
    always_comb begin
        port_en_s   = '0;
        port_addr_s = '0;
        port_data_s = '0;
        lvt_data_s  = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            port_en_s[w]   = wr_win_s[w];
            port_addr_s[w] = WrAddr_DI[w];
            port_data_s[w] = WrData_DI[w];
            lvt_data_s[w]  = LVT_W'(w);
        end
        if (sweep_s) begin
            port_en_s[0]   = 1'b1;
            port_addr_s[0] = init_cnt_q;
            port_data_s[0] = '0;
            lvt_data_s[0]  = '0;
        end else begin
            port_en_s[0] = wr_win_s[0];
        end
    end

    for (genvar g = 0; g < NUM_WR; g++) begin : g_bank
        lvt_ram_bank #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_DEPTH (DATA_DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_RD     (NUM_RD),
            .NUM_WP     (1)
        ) u_bank (
            .clk     (Clk_CI),
            .wr_en   (port_en_s[g]),
            .wr_addr (port_addr_s[g]),
            .wr_data (port_data_s[g]),
            .rd_addr (RdAddr_DI),
            .rd_data (bank_rdata_s[g])
        );
    end

    // Winners always target distinct addresses, so the LVT takes every port at once.
    lvt_ram_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .DATA_WIDTH (LVT_W),
        .NUM_RD     (NUM_RD),
        .NUM_WP     (NUM_WR)
    ) u_lvt (
        .clk     (Clk_CI),
        .wr_en   (port_en_s),
        .wr_addr (port_addr_s),
        .wr_data (lvt_data_s),
        .rd_addr (RdAddr_DI),
        .rd_data (lvt_rdata_s)
    );

    // Read mux: zero while sweeping or out of range, optional same-cycle bypass.
    always_comb begin
        logic [MAX_WR-1:0] hit_v;
        logic [LVT_W-1:0]  byp_sel;
        hit_v     = '0;
        byp_sel   = '0;
        rd_data_s = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            hit_v = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                hit_v[w] = wr_valid_s[w] && (WrAddr_DI[w] == RdAddr_DI[r]);
            end
            byp_sel = LVT_W'(lowest_set(hit_v));
            if (!ready_s || ({1'b0, RdAddr_DI[r]} >= DEPTH_X)) begin
                rd_data_s[r] = '0;
            end else if ((WR_BYPASS != 0) && (|hit_v)) begin
                rd_data_s[r] = WrData_DI[byp_sel];
            end else begin
                rd_data_s[r] = bank_rdata_s[lvt_rdata_s[r]][r];
            end
        end
    end

    assign Ready_SO       = ready_s;
    assign WrCollision_SO = coll_q;
    assign RdData_DO      = rd_data_s;

    lvt_ram_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .NUM_WR     (NUM_WR),
        .NUM_RD     (NUM_RD)
    ) u_chk (
        .clk (Clk_CI)
    );

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Bench for lvt_multiport_ram: a 12-deep no-bypass instance and a 16-deep
// bypass instance share stimulus and are checked against an array model.
module tb_lvt_multiport_ram;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int NWR = 2;
    localparam int NRD = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NWR-1:0]          wr_en;
    logic [NWR-1:0][AW-1:0]  wr_addr;
    logic [NWR-1:0][DW-1:0]  wr_data;
    logic [NRD-1:0][AW-1:0]  rd_addr;
    logic [NRD-1:0][DW-1:0]  rdd [2];
    logic [1:0]              rdy;
    logic [1:0]              coll;

    int        depth  [2] = '{12, 16};
    bit        bypass [2] = '{1'b0, 1'b1};
    logic [DW-1:0] mdl [2][16];
    int        rem [2];
    logic      exp_coll [2];
    int        n_cmp = 0;
    int        n_bad = 0;

    always #5 clk = ~clk;

    lvt_multiport_ram #(.ADDR_WIDTH(AW), .DATA_DEPTH(12), .DATA_WIDTH(DW),
                        .NUM_WR(NWR), .NUM_RD(NRD), .WR_BYPASS(0)) u_dut (
        .Clk_CI(clk), .Rst_RI(rst), .Ready_SO(rdy[0]), .WrEn_SI(wr_en),
        .WrAddr_DI(wr_addr), .WrData_DI(wr_data), .RdAddr_DI(rd_addr),
        .RdData_DO(rdd[0]), .WrCollision_SO(coll[0]));

    lvt_multiport_ram #(.ADDR_WIDTH(AW), .DATA_DEPTH(16), .DATA_WIDTH(DW),
                        .NUM_WR(NWR), .NUM_RD(NRD), .WR_BYPASS(1)) u_dut_bp (
        .Clk_CI(clk), .Rst_RI(rst), .Ready_SO(rdy[1]), .WrEn_SI(wr_en),
        .WrAddr_DI(wr_addr), .WrData_DI(wr_data), .RdAddr_DI(rd_addr),
        .RdData_DO(rdd[1]), .WrCollision_SO(coll[1]));

    // Expected read for instance k, port r, given the inputs currently driven.
    function automatic logic [DW-1:0] exp_rd(int k, int r);
        int a;
        a = int'(rd_addr[r]);
        if (rem[k] != 0 || a >= depth[k]) return '0;
        if (bypass[k] && !rst) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && int'(wr_addr[p]) == a) return wr_data[p];
            end
        end
        return mdl[k][a];
    endfunction

    // Advance the model by one edge using the current inputs, then the clock.
    task automatic clk_edge();
        for (int k = 0; k < 2; k++) begin
            exp_coll[k] = !rst && (rem[k] == 0) && wr_en[0] && wr_en[1]
                          && (wr_addr[0] == wr_addr[1]) && (int'(wr_addr[0]) < depth[k]);
            if (rst) begin
                rem[k] = depth[k];
                for (int a = 0; a < 16; a++) mdl[k][a] = '0;
            end else if (rem[k] > 0) begin
                rem[k] = rem[k] - 1;
            end else begin
                for (int p = NWR - 1; p >= 0; p--) begin
                    if (wr_en[p] && int'(wr_addr[p]) < depth[k]) mdl[k][wr_addr[p]] = wr_data[p];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int first [2];
        first = '{-1, -1};
        rst = 1'b1;
        wr_en = 2'b11; wr_addr[0] = 4'd2; wr_addr[1] = 4'd2;
        wr_data[0] = 32'h0BAD_0000; wr_data[1] = 32'h0BAD_0001;
        clk_edge();
        rst = 1'b0; wr_en = 2'b00;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (rdy[k] !== 1'b0) begin n_bad++; $display("FAIL reset_ready inst=%0d got=%b exp=0", k, rdy[k]); end
            n_cmp++; if (coll[k] !== 1'b0) begin n_bad++; $display("FAIL reset_coll inst=%0d got=%b exp=0", k, coll[k]); end
            n_cmp++; if (rdd[k] !== '0) begin n_bad++; $display("FAIL reset_rdata inst=%0d got=%h exp=0", k, rdd[k]); end
        end
        for (int c = 1; c <= 20; c++) begin
            for (int r = 0; r < NRD; r++) rd_addr[r] = AW'($urandom_range(15, 0));
            clk_edge();
            for (int k = 0; k < 2; k++) begin
                if (first[k] < 0 && rdy[k] === 1'b1) first[k] = c;
                n_cmp++; if (rdy[k] !== (rem[k] == 0)) begin n_bad++; $display("FAIL sweep_ready inst=%0d cyc=%0d got=%b exp=%b", k, c, rdy[k], rem[k] == 0); end
            end
        end
        n_cmp++; if (first[0] != 12) begin n_bad++; $display("FAIL sweep_len12 got=%0d exp=12", first[0]); end
        n_cmp++; if (first[1] != 16) begin n_bad++; $display("FAIL sweep_len16 got=%0d exp=16", first[1]); end
        for (int a = 0; a < 16; a++) begin
            for (int r = 0; r < NRD; r++) rd_addr[r] = AW'(a);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if (rdd[k] !== '0) begin n_bad++; $display("FAIL swept_zero inst=%0d addr=%0d got=%h exp=0", k, a, rdd[k]); end
            end
        end
    endtask

    task automatic test_per_port();
        wr_en = 2'b01; wr_addr[0] = 4'd3; wr_data[0] = 32'hA5A5_0001;
        for (int r = 0; r < NRD; r++) rd_addr[r] = 4'd3;
        clk_edge();
        wr_en = 2'b00; #1;
        for (int k = 0; k < 2; k++) for (int r = 0; r < NRD; r++) begin
            n_cmp++; if (rdd[k][r] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL port0_write inst=%0d port=%0d got=%h exp=a5a50001", k, r, rdd[k][r]); end
        end
        wr_en = 2'b10; wr_addr[1] = 4'd3; wr_data[1] = 32'h5A5A_0002;
        clk_edge();
        wr_en = 2'b00; #1;
        for (int k = 0; k < 2; k++) for (int r = 0; r < NRD; r++) begin
            n_cmp++; if (rdd[k][r] !== 32'h5A5A_0002) begin n_bad++; $display("FAIL port1_write inst=%0d port=%0d got=%h exp=5a5a0002", k, r, rdd[k][r]); end
        end
        rd_addr[1] = 4'd4; #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (rdd[k][1] !== 32'h0) begin n_bad++; $display("FAIL addr4_zero inst=%0d got=%h exp=0", k, rdd[k][1]); end
        end
    endtask

    task automatic test_collision();
        wr_en = 2'b11; wr_addr[0] = 4'd7; wr_addr[1] = 4'd7;
        wr_data[0] = 32'h11; wr_data[1] = 32'h22;
        for (int r = 0; r < NRD; r++) rd_addr[r] = 4'd7;
        #1;
        n_cmp++; if (rdd[1][0] !== 32'h11) begin n_bad++; $display("FAIL coll_bypass got=%h exp=11", rdd[1][0]); end
        clk_edge();
        wr_en = 2'b00; #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (coll[k] !== 1'b1) begin n_bad++; $display("FAIL coll_pulse inst=%0d got=%b exp=1", k, coll[k]); end
            n_cmp++; if (rdd[k][2] !== 32'h11) begin n_bad++; $display("FAIL coll_winner inst=%0d got=%h exp=11", k, rdd[k][2]); end
        end
        clk_edge();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (coll[k] !== 1'b0) begin n_bad++; $display("FAIL coll_clear inst=%0d got=%b exp=0", k, coll[k]); end
        end
    endtask

    task automatic test_back_to_back();
        wr_en = 2'b11; wr_addr[0] = 4'd5; wr_addr[1] = 4'd5;
        for (int c = 0; c < 2; c++) begin
            wr_data[0] = 32'h100 + 32'(c); wr_data[1] = 32'h200 + 32'(c);
            clk_edge();
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if (coll[k] !== 1'b1) begin n_bad++; $display("FAIL b2b_coll inst=%0d cyc=%0d got=%b exp=1", k, c, coll[k]); end
            end
        end
        wr_en = 2'b00; rd_addr[0] = 4'd5;
        clk_edge();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (coll[k] !== 1'b0) begin n_bad++; $display("FAIL b2b_clear inst=%0d got=%b exp=0", k, coll[k]); end
            n_cmp++; if (rdd[k][0] !== 32'h101) begin n_bad++; $display("FAIL b2b_data inst=%0d got=%h exp=101", k, rdd[k][0]); end
        end
    endtask

    task automatic test_bypass();
        wr_en = 2'b01; wr_addr[0] = 4'd9; wr_data[0] = 32'h1234;
        clk_edge();
        wr_en = 2'b10; wr_addr[1] = 4'd9; wr_data[1] = 32'hDEAD; rd_addr[2] = 4'd9;
        #1;
        n_cmp++; if (rdd[0][2] !== 32'h1234) begin n_bad++; $display("FAIL nobypass_old got=%h exp=1234", rdd[0][2]); end
        n_cmp++; if (rdd[1][2] !== 32'hDEAD) begin n_bad++; $display("FAIL bypass_same got=%h exp=dead", rdd[1][2]); end
        clk_edge();
        wr_en = 2'b00; #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (rdd[k][2] !== 32'hDEAD) begin n_bad++; $display("FAIL bypass_next inst=%0d got=%h exp=dead", k, rdd[k][2]); end
        end
    endtask

    task automatic test_out_of_range();
        wr_en = 2'b11; wr_addr[0] = 4'd13; wr_addr[1] = 4'd13;
        wr_data[0] = 32'hFF; wr_data[1] = 32'hEE;
        clk_edge();
        wr_en = 2'b00; rd_addr[0] = 4'd13; #1;
        n_cmp++; if (coll[0] !== 1'b0) begin n_bad++; $display("FAIL oor_nocoll got=%b exp=0", coll[0]); end
        n_cmp++; if (coll[1] !== 1'b1) begin n_bad++; $display("FAIL inrange_coll got=%b exp=1", coll[1]); end
        n_cmp++; if (rdd[0][0] !== 32'h0) begin n_bad++; $display("FAIL oor_read got=%h exp=0", rdd[0][0]); end
        n_cmp++; if (rdd[1][0] !== 32'hFF) begin n_bad++; $display("FAIL inrange_read got=%h exp=ff", rdd[1][0]); end
        for (int a = 0; a < 16; a++) begin
            for (int r = 0; r < NRD; r++) rd_addr[r] = AW'(a);
            #1;
            for (int k = 0; k < 2; k++) for (int r = 0; r < NRD; r++) begin
                n_cmp++; if (rdd[k][r] !== exp_rd(k, r)) begin n_bad++; $display("FAIL oor_sweep inst=%0d addr=%0d got=%h exp=%h", k, a, rdd[k][r], exp_rd(k, r)); end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(63, 0) == 0);
            for (int p = 0; p < NWR; p++) begin
                wr_en[p]   = $urandom_range(1, 0) == 1;
                wr_addr[p] = ($urandom_range(1, 0) == 1) ? AW'($urandom_range(3, 0)) : AW'($urandom_range(15, 0));
                wr_data[p] = $urandom;
            end
            for (int r = 0; r < NRD; r++) rd_addr[r] = AW'($urandom_range(15, 0));
            #1;
            for (int k = 0; k < 2; k++) for (int r = 0; r < NRD; r++) begin
                n_cmp++; if (rdd[k][r] !== exp_rd(k, r)) begin n_bad++; $display("FAIL rand_read inst=%0d port=%0d addr=%0d got=%h exp=%h", k, r, rd_addr[r], rdd[k][r], exp_rd(k, r)); end
            end
            clk_edge();
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if (coll[k] !== exp_coll[k]) begin n_bad++; $display("FAIL rand_coll inst=%0d got=%b exp=%b", k, coll[k], exp_coll[k]); end
                n_cmp++; if (rdy[k] !== (rem[k] == 0)) begin n_bad++; $display("FAIL rand_ready inst=%0d got=%b exp=%b", k, rdy[k], rem[k] == 0); end
            end
        end
        rst = 1'b0; wr_en = 2'b00;
    endtask

    task automatic test_reset_mid();
        int first [2];
        first = '{-1, -1};
        rst = 1'b1; clk_edge(); rst = 1'b0;
        for (int c = 0; c < 20; c++) clk_edge();
        for (int c = 0; c < 6; c++) begin
            wr_en = 2'b11;
            for (int p = 0; p < NWR; p++) begin
                wr_addr[p] = AW'($urandom_range(15, 0));
                wr_data[p] = $urandom | 32'h1;
            end
            clk_edge();
        end
        wr_en = 2'b00;
        rst = 1'b1; clk_edge(); rst = 1'b0;
        for (int c = 0; c < 5; c++) clk_edge();
        rst = 1'b1; clk_edge(); rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            clk_edge();
            for (int k = 0; k < 2; k++) if (first[k] < 0 && rdy[k] === 1'b1) first[k] = c;
        end
        n_cmp++; if (first[0] != 12) begin n_bad++; $display("FAIL restart_len12 got=%0d exp=12", first[0]); end
        n_cmp++; if (first[1] != 16) begin n_bad++; $display("FAIL restart_len16 got=%0d exp=16", first[1]); end
        for (int a = 0; a < 16; a++) begin
            for (int r = 0; r < NRD; r++) rd_addr[r] = AW'(a);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if (rdd[k] !== '0) begin n_bad++; $display("FAIL restart_zero inst=%0d addr=%0d got=%h exp=0", k, a, rdd[k]); end
            end
        end
    endtask

    initial begin
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        rem     = '{16, 16};
        test_reset();
        test_per_port();
        test_collision();
        test_back_to_back();
        test_bypass();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
